// File: rtl/step_display_mux_pkg.sv
// Shared types and constants for the step/distance seven-segment display path.
package step_display_mux_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StLatch
    } conv_state_e;

    typedef logic [3:0] bcd_digit_t;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    localparam int unsigned CLAMP_MAX_DEFAULT = 9999;

    // Active-low segment patterns, entry 0 in the low slice.
    localparam logic [9:0][6:0] SEG_LUT = {
        7'h10, 7'h00, 7'h78, 7'h02, 7'h12,
        7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

endpackage

// File: rtl/bin2bcd_seq.sv
// Clamped sequential double-dabble converter: 16-bit binary in, four BCD digits out.
module bin2bcd_seq
    import step_display_mux_pkg::*;
#(
    parameter int unsigned CLAMP_MAX = CLAMP_MAX_DEFAULT
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic [15:0] bin_i,
    output logic [15:0] bcd_o,
    output logic        done_o
);

    localparam logic [15:0] ClampVal = 16'(CLAMP_MAX);

    conv_state_e state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] sh_q, sh_d;
    logic [15:0] last_q, last_d;
    logic        force_q, force_d;
    logic [31:0] adj;
    logic [15:0] clamped;

    assign clamped = (bin_i > ClampVal) ? ClampVal : bin_i;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sh_d    = sh_q;
        last_d  = last_q;
        force_d = force_q;
        adj     = sh_q;
        unique case (state_q)
            StIdle: begin
                if ((bin_i != last_q) || force_q) begin
                    sh_d    = {16'h0000, clamped};
                    last_d  = bin_i;
                    force_d = 1'b0;
                    cnt_d   = 5'd0;
                    state_d = StShift;
                end
            end
            StShift: begin
                for (int i = 0; i < 4; i++) begin
                    if (adj[16 + 4*i +: 4] >= 4'd5) begin
                        adj[16 + 4*i +: 4] = adj[16 + 4*i +: 4] + 4'd3;
                    end
                end
                sh_d  = adj << 1;
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd15) begin
                    state_d = StLatch;
                end
            end
            StLatch: begin
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= StIdle;
            cnt_q   <= 5'd0;
            sh_q    <= 32'h0;
            last_q  <= 16'h0;
            force_q <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sh_q    <= sh_d;
            last_q  <= last_d;
            force_q <= force_d;
        end
    end

    assign bcd_o  = sh_q[31:16];
    assign done_o = (state_q == StLatch);

endmodule

// File: rtl/step_display_mux.sv
// Four-digit multiplexed seven-segment driver for the step/distance display word.
// Optional leading-zero blanking is enabled by defining LEAD_ZERO_BLANK_EN.
module step_display_mux
    import step_display_mux_pkg::*;
#(
    parameter int unsigned REFRESH_DIV = 100000,
    parameter int unsigned CLAMP_MAX   = CLAMP_MAX_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] fitbit_data,
    input  logic        is_miles,
    output logic [3:0]  an,
    output logic [6:0]  sseg,
    output logic        dp
);

    localparam int unsigned CntW = $clog2(REFRESH_DIV);

    logic [CntW-1:0] cnt_q, cnt_d;
    logic [1:0]      idx_q, idx_d;
    logic [15:0]     disp_q, disp_d;
    logic [3:0]      an_q, an_d;
    logic [6:0]      sseg_q, sseg_d;
    logic            dp_q, dp_d;
    logic [15:0]     conv_bcd;
    logic            conv_done;
    bcd_digit_t      digit;
    logic            blank;

    bin2bcd_seq #(
        .CLAMP_MAX(CLAMP_MAX)
    ) u_conv (
        .clk_i  (clk),
        .reset_i(reset),
        .bin_i  (fitbit_data),
        .bcd_o  (conv_bcd),
        .done_o (conv_done)
    );

    always_comb begin
        cnt_d  = cnt_q + CntW'(1);
        idx_d  = idx_q;
        disp_d = conv_done ? conv_bcd : disp_q;
        if (cnt_q == CntW'(REFRESH_DIV - 1)) begin
            cnt_d = '0;
            idx_d = idx_q + 2'd1;
        end

        unique case (idx_q)
            2'd0: digit = disp_q[3:0];
            2'd1: digit = disp_q[7:4];
            2'd2: digit = disp_q[11:8];
            default: digit = disp_q[15:12];
        endcase

        blank = 1'b0;
`ifdef LEAD_ZERO_BLANK_EN
        // Ones never blank; tens stays lit in miles mode so 5 reads as 0.5.
        unique case (idx_q)
            2'd3: blank = (disp_q[15:12] == 4'd0);
            2'd2: blank = (disp_q[15:8] == 8'd0);
            2'd1: blank = (disp_q[15:4] == 12'd0) && !is_miles;
            default: blank = 1'b0;
        endcase
`endif

        an_d   = ~(4'b0001 << idx_q);
        sseg_d = (blank || (digit > 4'd9)) ? SEG_BLANK : SEG_LUT[digit];
        dp_d   = !(is_miles && (idx_q == 2'd1));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q  <= '0;
            idx_q  <= 2'd0;
            disp_q <= 16'h0000;
            an_q   <= 4'b1111;
            sseg_q <= SEG_BLANK;
            dp_q   <= 1'b1;
        end else begin
            cnt_q  <= cnt_d;
            idx_q  <= idx_d;
            disp_q <= disp_d;
            an_q   <= an_d;
            sseg_q <= sseg_d;
            dp_q   <= dp_d;
        end
    end

    assign an   = an_q;
    assign sseg = sseg_q;
    assign dp   = dp_q;

endmodule

// File: tb/tb_step_display_mux.sv
// Self-checking bench for step_display_mux with a fast refresh divider.
module tb_step_display_mux;

    localparam int unsigned RefreshDiv = 4;

    logic        clk;
    logic        reset;
    logic [15:0] fitbit_data;
    logic        is_miles;
    logic [3:0]  an;
    logic [6:0]  sseg;
    logic        dp;

    int checks = 0;
    int errors = 0;
    int ncyc   = 0;

    logic [6:0] seg_tab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
    int pow10 [4] = '{1, 10, 100, 1000};

    step_display_mux #(
        .REFRESH_DIV(RefreshDiv),
        .CLAMP_MAX  (9999)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .fitbit_data(fitbit_data),
        .is_miles   (is_miles),
        .an         (an),
        .sseg       (sseg),
        .dp         (dp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Non-reset edges seen since the last reset edge.
    always @(posedge clk) begin
        if (reset) ncyc <= 0;
        else       ncyc <= ncyc + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [6:0] exp_seg(input int v, input int idx, input bit miles);
        int  c;
        int  d;
        bit  blank;
        c = (v > 9999) ? 9999 : v;
        d = (c / pow10[idx]) % 10;
        blank = 1'b0;
`ifdef LEAD_ZERO_BLANK_EN
        if (idx != 0 && !(miles && idx == 1) && c < pow10[idx]) blank = 1'b1;
`endif
        return blank ? 7'h7F : seg_tab[d];
    endfunction

    // Scan one full 16-cycle frame and check every digit slot.
    task automatic frame(input string tag, input int v, input bit miles);
        int idx;
        for (int k = 0; k < 16; k++) begin
            tick();
            idx = ((ncyc - 1) / RefreshDiv) % 4;
            check($sformatf("%s_an%0d", tag, k), {12'h0, an}, {12'h0, ~(4'b0001 << idx)});
            check($sformatf("%s_seg%0d", tag, k), {9'h0, sseg}, {9'h0, exp_seg(v, idx, miles)});
            check($sformatf("%s_dp%0d", tag, k), {15'h0, dp},
                  {15'h0, !(miles && idx == 1)});
        end
    endtask

    initial begin
        int v;
        bit m;
        reset       = 1'b1;
        fitbit_data = 16'd0;
        is_miles    = 1'b0;
        tick();
        tick();
        check("rst_an", {12'h0, an}, 16'h000F);
        check("rst_seg", {9'h0, sseg}, 16'h007F);
        check("rst_dp", {15'h0, dp}, 16'h0001);

        // First IDLE edge after reset samples; display updates 17 edges later.
        fitbit_data = 16'd1234;
        reset = 1'b0;
        repeat (17) tick();
        check("lat_hold", dut.disp_q, 16'h0000);
        tick();
        check("lat_1234", dut.disp_q, 16'h1234);
        frame("f1234", 1234, 1'b0);

        fitbit_data = 16'hFFFF;
        repeat (40) tick();
        frame("fclamp", 65535, 1'b0);

        fitbit_data = 16'd57;
        is_miles = 1'b1;
        repeat (40) tick();
        frame("fmiles57", 57, 1'b1);
        is_miles = 1'b0;

        // Change input during SHIFT: 100 completes first, 200 follows.
        fitbit_data = 16'd100;
        tick();
        repeat (5) tick();
        fitbit_data = 16'd200;
        repeat (11) tick();
        check("mid_pre100", dut.disp_q, 16'h0057);
        tick();
        check("mid_100", dut.disp_q, 16'h0100);
        repeat (17) tick();
        check("mid_hold100", dut.disp_q, 16'h0100);
        tick();
        check("mid_200", dut.disp_q, 16'h0200);
        frame("f200", 200, 1'b0);

        // Reset in the middle of a conversion.
        fitbit_data = 16'd4321;
        tick();
        repeat (6) tick();
        reset = 1'b1;
        tick();
        check("mrst_an", {12'h0, an}, 16'h000F);
        check("mrst_seg", {9'h0, sseg}, 16'h007F);
        check("mrst_dp", {15'h0, dp}, 16'h0001);
        check("mrst_disp", dut.disp_q, 16'h0000);
        reset = 1'b0;
        repeat (40) tick();
        check("mrst_reconv", dut.disp_q, 16'h4321);
        frame("f4321", 4321, 1'b0);

        fitbit_data = 16'd0;
        repeat (40) tick();
        frame("fzero", 0, 1'b0);

        for (int r = 0; r < 8; r++) begin
            v = int'($urandom_range(0, 65535));
            if (r % 2 == 1) v = v % 200;
            m = bit'($urandom_range(0, 1));
            fitbit_data = 16'(v);
            is_miles = m;
            repeat (40) tick();
            frame($sformatf("frand%0d", r), v, m);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
